// File: rtl/if_id_buffer_if.sv
// ----------------------------------------------------------------------------
// if_id_buffer_if
//   Bundle of the fetch-side and decode-side handshake signals of the IF/ID
//   instruction buffer.
//
//   Fetch side : flush, in_valid, in_pc, in_pc4, in_inst  ->  buffer
//                in_ready                                 <-  buffer
//   Decode side: out_ready                                ->  buffer
//                out_valid, out_pc, out_pc4, out_inst     <-  buffer
//   Status     : count (occupied entries)                 <-  buffer
//
//   Modports:
//     slave  - the buffer itself
//     master - the surrounding pipeline (fetch + decode), or a testbench
// ----------------------------------------------------------------------------
interface if_id_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc4;
    logic [XLEN-1:0] in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc4;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;
    logic [CW-1:0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_pc4, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_pc4, out_inst, count
    );

    modport master (
        output flush, in_valid, in_pc, in_pc4, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4, out_inst, count
    );
endinterface

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
//   Instruction buffer / pipeline register between fetch and decode.
//   A DEPTH-entry circular FIFO of {pc, pc4, inst} tuples with valid/ready
//   handshakes on both sides. A flush (taken branch) empties the buffer and
//   drops the tuple offered in the same cycle. When empty, decode sees
//   out_valid=0 and NOP_INST.
//
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-low reset
//     bus   - if_id_buffer_if.slave: fetch/decode handshake and count
// ----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input logic          clk,
    input logic          reset,
    if_id_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    // Handshakes only depend on registered count, never on out_ready, so
    // a pop at full does not open in_ready until the next cycle.
    assign push = bus.in_valid  && bus.in_ready  && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            // NOTE: entries are reset only so out_pc/out_pc4 read as zero
            // straight out of reset; the FIFO logic never relies on it.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every read in this
            // block sees the pre-edge values of pointers and count.
            if (push) begin
                mem[wr_ptr] <= '{pc: bus.in_pc, pc4: bus.in_pc4, inst: bus.in_inst};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.in_ready  = (cnt != FULL_COUNT);
    assign bus.out_valid = (cnt != '0);
    assign bus.out_pc    = mem[rd_ptr].pc;
    assign bus.out_pc4   = mem[rd_ptr].pc4;
    assign bus.out_inst  = bus.out_valid ? mem[rd_ptr].inst : NOP_INST;
    assign bus.count     = cnt;

endmodule

// File: tb/tb_if_id_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_id_buffer
//   Directed, table-driven bench for if_id_buffer (XLEN=32, DEPTH=2).
//   Each vector is applied for one clock; outputs are sampled 1 time unit
//   after the rising edge. Reset and async mid-cycle reset are hand-written.
// ----------------------------------------------------------------------------
module tb_if_id_buffer;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;

    if_id_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic        out_ready;
        logic        flush;
        int          exp_count;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[$];

    // Distinct instruction word per pc; pc=0 gives addi x1,x0,5 (0x00500093).
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0050_0093 + (pc << 8);
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic fl,
                                input int ec, input logic ev,
                                input logic [31:0] epc, input logic eir);
        vec_t v;
        v.in_valid = iv; v.pc = pc; v.out_ready = ordy; v.flush = fl;
        v.exp_count = ec; v.exp_valid = ev; v.exp_pc = epc; v.exp_in_ready = eir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_pc4    = pc + 32'd4;
        bus.in_inst   = inst_of(pc);
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic check_outputs(input string tag, input int ec, input logic ev,
                                 input logic [31:0] epc, input logic eir);
        check({tag, " count"},     32'(bus.count),     32'(ec));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, " in_ready"},  32'(bus.in_ready),  32'(eir));
        if (ev) begin
            check({tag, " out_pc"},   bus.out_pc,   epc);
            check({tag, " out_pc4"},  bus.out_pc4,  epc + 32'd4);
            check({tag, " out_inst"}, bus.out_inst, inst_of(epc));
        end else begin
            check({tag, " out_inst"}, bus.out_inst, NOP);
        end
    endtask

    initial begin
        // Single push, fill to full, offer while full, stall, drain.
        vecs.push_back(mk(1, 32'h00, 0, 0, 1, 1, 32'h00, 1));
        vecs.push_back(mk(1, 32'h04, 0, 0, 2, 1, 32'h00, 0));
        vecs.push_back(mk(1, 32'h08, 0, 0, 2, 1, 32'h00, 0));
        vecs.push_back(mk(0, 32'h08, 0, 0, 2, 1, 32'h00, 0));
        vecs.push_back(mk(0, 32'h00, 1, 0, 1, 1, 32'h04, 1));
        vecs.push_back(mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1));
        // Empty: out_ready ignored, no underflow.
        vecs.push_back(mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1));
        // Streaming across pointer wrap, count stays 1.
        vecs.push_back(mk(1, 32'h00, 1, 0, 1, 1, 32'h00, 1));
        vecs.push_back(mk(1, 32'h04, 1, 0, 1, 1, 32'h04, 1));
        vecs.push_back(mk(1, 32'h08, 1, 0, 1, 1, 32'h08, 1));
        vecs.push_back(mk(1, 32'h0C, 1, 0, 1, 1, 32'h0C, 1));
        vecs.push_back(mk(1, 32'h10, 1, 0, 1, 1, 32'h10, 1));
        vecs.push_back(mk(0, 32'h00, 1, 0, 0, 0, 32'h00, 1));
        // Fill, then flush with an incoming tuple; branch target follows.
        vecs.push_back(mk(1, 32'h00, 0, 0, 1, 1, 32'h00, 1));
        vecs.push_back(mk(1, 32'h04, 0, 0, 2, 1, 32'h00, 0));
        vecs.push_back(mk(1, 32'h08, 1, 1, 0, 0, 32'h00, 1));
        vecs.push_back(mk(1, 32'h40, 0, 0, 1, 1, 32'h40, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0, 2, 1, 32'h40, 0));
        // Pop at full: push refused this cycle, accepted the next.
        vecs.push_back(mk(1, 32'h48, 1, 0, 1, 1, 32'h44, 1));
        vecs.push_back(mk(1, 32'h48, 1, 0, 1, 1, 32'h48, 1));
        vecs.push_back(mk(1, 32'h4C, 0, 0, 2, 1, 32'h48, 0));

        drive(0, 32'h0, 0, 0);
        reset = 1'b0;
        #3;
        check_outputs("reset", 0, 0, 32'h0, 1);
        check("reset out_pc", bus.out_pc, 32'h0);
        check("reset out_pc4", bus.out_pc4, 32'h0);
        #7;
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].in_valid, vecs[i].pc, vecs[i].out_ready, vecs[i].flush);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                          vecs[i].exp_pc, vecs[i].exp_in_ready);
        end

        // Async reset between edges while full (count=2).
        drive(0, 32'h0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0, 32'h0, 1);
        check("async_reset out_pc", bus.out_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Flush on an empty buffer is harmless; then resume normally.
        drive(0, 32'h0, 1, 1);
        @(posedge clk);
        #1;
        check_outputs("empty_flush", 0, 0, 32'h0, 1);
        drive(1, 32'h80, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("resume", 1, 1, 32'h80, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Instruction buffer and pipeline register between the fetch stage (if_stage) and the decode stage.
- Captures each fetched {pc, pc4, inst} tuple and presents it to decode with a valid/ready handshake.
- Decouples fetch from decode stalls and discards everything it holds on a taken branch (flush).
- Parameterised circular FIFO; an empty buffer presents a NOP to decode.

Parameters:
- XLEN, 32, width of pc, pc4 and instruction words
- DEPTH, 2, number of entries; power of two, at least 2
- NOP_INST, 32'h00000013, instruction presented when empty (addi x0,x0,0)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  taken branch/jump (pc_src); discard all held and incoming entries
- in_valid  input  1  fetch presents a valid tuple
- in_pc  input  XLEN  address of the fetched instruction (inst_addr from fetch)
- in_pc4  input  XLEN  in_pc + 4 from fetch
- in_inst  input  XLEN  instruction word read from instruction memory
- in_ready  output  1  buffer can accept a tuple this cycle
- out_valid  output  1  head entry is valid for decode
- out_pc  output  XLEN  head entry pc
- out_pc4  output  XLEN  head entry pc4
- out_inst  output  XLEN  head entry instruction, or NOP_INST when empty
- out_ready  input  1  decode consumes the head this cycle (deasserted = stall)
- count  output  clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Storage: DEPTH entries of {pc, pc4, inst}; wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.
- Reset (reset=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0.
  - out_valid=0, out_pc=0, out_pc4=0, out_inst=NOP_INST.
  - in_ready=1 immediately.
  - Entry contents are don't-care.
- in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- Push: occurs when in_valid && in_ready && !flush. The tuple is written at wr_ptr and wr_ptr increments.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr increments.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged (legal whenever count is between 1 and DEPTH-1)
- Outputs are driven combinationally from the entry at rd_ptr.
  - out_valid = (count != 0).
  - When count==0: out_inst=NOP_INST, and out_pc and out_pc4 hold their last values (don't-care).
- Latency: a tuple pushed at edge N is visible at out_* after edge N. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Full: in_ready=0 and fetch must hold its tuple. A pop at full frees a slot, but the push is not accepted until the following cycle.
- Empty: out_valid=0. out_ready is ignored and no underflow occurs.
- Flush:
  - Has priority over push and pop.
  - At the next edge: count=0, wr_ptr=0, rd_ptr=0.
  - The incoming tuple in the flush cycle is dropped.
  - Decode sees out_valid=0 and NOP_INST in the following cycle.
- Flush with in_valid=0 or an empty buffer is harmless.
- Reset mid-operation discards all contents immediately, regardless of clk.
- Ordering: strictly FIFO. No entry is duplicated or skipped across pointer wrap.
- in_valid may drop without a handshake; the buffer takes no action when in_valid=0.

Test Plan:
- Reset and single push:
  - Stimulus: hold reset=0 for 10 time units, then release; push pc=0x0, pc4=0x4, inst=0x00500093 with out_ready=0.
  - Response: count=0 and out_inst=0x13 during reset; one cycle after the push, out_valid=1, out_pc=0x0, out_pc4=0x4, out_inst=0x00500093, count=1.
- Fill to full:
  - Stimulus: with out_ready=0, push pc=0x0 and pc=0x4 (DEPTH=2), then offer pc=0x8.
  - Response: count=2, in_ready=0; the pc=0x8 tuple is not accepted; out_pc stays 0x0.
- Streaming:
  - Stimulus: out_ready=1 and in_valid=1 every cycle with pc=0x0,0x4,0x8,0xC,0x10 (fetch chaining pc4 into pc).
  - Response: decode sees the same sequence one cycle later, with no gaps after the first; count stays at 1.
- Stall then drain:
  - Stimulus: fill 2 entries, hold out_ready=0 for 3 cycles, then set out_ready=1.
  - Response: out_pc stays 0x0 during the stall, then shows 0x0 then 0x4; count goes 2 to 1 to 0, then out_valid=0 and out_inst=0x13.
- Flush:
  - Stimulus: with count=2, assert flush together with in_valid (pc=0x8).
  - Response: the next cycle has count=0, out_valid=0, out_inst=0x13; the pc=0x8 tuple is absent; a push of branch target pc=0x40 then appears as the next out_pc.
- Async reset mid-operation:
  - Stimulus: with count=2, drive reset=0 between clock edges.
  - Response: count=0, out_valid=0 and out_inst=0x13 immediately, without waiting for a clk edge; normal operation resumes after release.
